// File: rtl/program_sequencer.sv
// Program counter with absolute/conditional/relative branching, stall and an optional
// return-address stack for CALL/RET, enabled by defining PROGRAM_SEQUENCER_STACK_EN.
module program_sequencer #(
   parameter int                ADDR_W      = 6,
   parameter int                STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = {ADDR_W{1'b0}}
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic [2:0]                       op,
   input  logic [ADDR_W-1:0]                target,
   input  logic                             cond,
   input  logic                             clr_err,
   output logic [ADDR_W-1:0]                pc,
   output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
   output logic                             stk_ovf,
   output logic                             stk_unf
);

   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   localparam logic [2:0] OP_NEXT = 3'b000;
   localparam logic [2:0] OP_JUMP = 3'b001;
   localparam logic [2:0] OP_BR   = 3'b010;
   localparam logic [2:0] OP_BREL = 3'b011;
   localparam logic [2:0] OP_CALL = 3'b100;
   localparam logic [2:0] OP_RET  = 3'b101;

   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_nxt_s;
   logic [ADDR_W-1:0] pc_inc_s;

   assign pc_inc_s = pc_r + ADDR_W'(1'b1);

`ifdef PROGRAM_SEQUENCER_STACK_EN
   localparam int                 IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [DEPTH_W-1:0] FULL  = DEPTH_W'(STACK_DEPTH);

   logic [ADDR_W-1:0]  stack_r [STACK_DEPTH];
   logic [DEPTH_W-1:0] depth_r;
   logic [DEPTH_W-1:0] top_ptr_s;
   logic [ADDR_W-1:0]  top_s;
   logic               push_s;
   logic               pop_s;
   logic               ovf_set_s;
   logic               unf_set_s;
   logic               ovf_r;
   logic               unf_r;

   // top_s is garbage when the stack is empty; RET then takes the underflow path instead
   assign top_ptr_s = depth_r - DEPTH_W'(1'b1);
   assign top_s     = stack_r[top_ptr_s[IDX_W-1:0]];
`endif

   // next-PC selection and stack push/pop/error decode
   always_comb begin
      pc_nxt_s  = pc_r;
`ifdef PROGRAM_SEQUENCER_STACK_EN
      push_s    = 1'b0;
      pop_s     = 1'b0;
      ovf_set_s = 1'b0;
      unf_set_s = 1'b0;
`endif
      if (en) begin
         case (op)
            OP_NEXT: pc_nxt_s = pc_inc_s;
            OP_JUMP: pc_nxt_s = target;
            OP_BR:   pc_nxt_s = cond ? target : pc_inc_s;
            OP_BREL: pc_nxt_s = cond ? (pc_r + target) : pc_inc_s;
`ifdef PROGRAM_SEQUENCER_STACK_EN
            OP_CALL: begin
               pc_nxt_s = target;
               if (depth_r == FULL) begin
                  ovf_set_s = 1'b1;
               end else begin
                  push_s = 1'b1;
               end
            end
            OP_RET: begin
               if (depth_r == {DEPTH_W{1'b0}}) begin
                  pc_nxt_s  = pc_inc_s;
                  unf_set_s = 1'b1;
               end else begin
                  pc_nxt_s = top_s;
                  pop_s    = 1'b1;
               end
            end
`else
            OP_CALL: pc_nxt_s = target;
            OP_RET:  pc_nxt_s = pc_inc_s;
`endif
            default: pc_nxt_s = pc_inc_s;
         endcase
      end else begin
         pc_nxt_s = pc_r;
      end
   end

   // program counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_ADDR;
      end else begin
         pc_r <= pc_nxt_s;
      end
   end

`ifdef PROGRAM_SEQUENCER_STACK_EN
   // return-address storage and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth_r <= {DEPTH_W{1'b0}};
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_r[i] <= {ADDR_W{1'b0}};
         end
      end else if (push_s) begin
         stack_r[depth_r[IDX_W-1:0]] <= pc_inc_s;
         depth_r                     <= depth_r + DEPTH_W'(1'b1);
      end else if (pop_s) begin
         depth_r <= depth_r - DEPTH_W'(1'b1);
      end
   end

   // sticky error flags; a new error in the same cycle beats clr_err
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else begin
         if (ovf_set_s) begin
            ovf_r <= 1'b1;
         end else if (clr_err) begin
            ovf_r <= 1'b0;
         end
         if (unf_set_s) begin
            unf_r <= 1'b1;
         end else if (clr_err) begin
            unf_r <= 1'b0;
         end
      end
   end

   assign depth   = depth_r;
   assign stk_ovf = ovf_r;
   assign stk_unf = unf_r;
`else
   logic unused_clr_err_s;

   assign unused_clr_err_s = clr_err;
   assign depth            = {DEPTH_W{1'b0}};
   assign stk_ovf          = 1'b0;
   assign stk_unf          = 1'b0;
`endif

   assign pc = pc_r;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed scoreboard bench for program_sequencer (ADDR_W=6, STACK_DEPTH=4, RESET_ADDR=0);
// expectations follow PROGRAM_SEQUENCER_STACK_EN when it is defined.
module tb_program_sequencer;

   typedef struct packed {
      logic [5:0] pc;
      logic [2:0] depth;
      logic       ovf;
      logic       unf;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [2:0] op;
   logic [5:0] target;
   logic       cond;
   logic       clr_err;
   logic [5:0] pc;
   logic [2:0] depth;
   logic       stk_ovf;
   logic       stk_unf;

   exp_t  exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    bad   = 0;

   program_sequencer #(.ADDR_W(6), .STACK_DEPTH(4), .RESET_ADDR(6'd0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .op(op), .target(target), .cond(cond),
      .clr_err(clr_err), .pc(pc), .depth(depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_out();
      exp_t  e;
      exp_t  o;
      string t;
      o = '{pc: pc, depth: depth, ovf: stk_ovf, unf: stk_unf};
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty: output pc=%0d with no expectation queued", pc);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (o === e) else begin
            bad++;
            $error("FAIL %s: got pc=%0d depth=%0d ovf=%b unf=%b, want pc=%0d depth=%0d ovf=%b unf=%b",
                   t, o.pc, o.depth, o.ovf, o.unf, e.pc, e.depth, e.ovf, e.unf);
         end
      end
   endtask

   task automatic step(input logic e, input logic [2:0] o, input logic [5:0] t, input logic c,
                       input logic clr, input logic [5:0] xp, input logic [2:0] xd,
                       input logic xo, input logic xu, input string tag);
      @(negedge clk);
      en = e; op = o; target = t; cond = c; clr_err = clr;
      exp_q.push_back('{pc: xp, depth: xd, ovf: xo, unf: xu});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; op = 3'b000; target = 6'd0; cond = 1'b0; clr_err = 1'b0;
      #12;
      total++;
      assert ({pc, depth, stk_ovf, stk_unf} === {6'd0, 3'd0, 1'b0, 1'b0}) else begin
         bad++;
         $error("FAIL reset_state: got pc=%0d depth=%0d ovf=%b unf=%b, want 0/0/0/0",
                pc, depth, stk_ovf, stk_unf);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 64; i++) begin
         step(1'b1, 3'b000, 6'd0, 1'b0, 1'b0, 6'((i + 1) % 64), 3'd0, 1'b0, 1'b0, "next_wrap");
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 3'b000, 6'd0, 1'b0, 1'b0, 6'(i + 1), 3'd0, 1'b0, 1'b0, "next_run");
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      assert (pc === 6'd0) else begin
         bad++;
         $error("FAIL async_reset: got pc=%0d, want 0", pc);
      end
      @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 3'b001, 6'd10, 1'b0, 1'b0, 6'd10, 3'd0, 1'b0, 1'b0, "jump10");
      step(1'b1, 3'b010, 6'd40, 1'b0, 1'b0, 6'd11, 3'd0, 1'b0, 1'b0, "br_not_taken");
      step(1'b1, 3'b010, 6'd40, 1'b1, 1'b0, 6'd40, 3'd0, 1'b0, 1'b0, "br_taken");
      step(1'b1, 3'b011, 6'b111100, 1'b1, 1'b0, 6'd36, 3'd0, 1'b0, 1'b0, "brel_back4");
      step(1'b1, 3'b001, 6'd62, 1'b0, 1'b0, 6'd62, 3'd0, 1'b0, 1'b0, "jump62");
      step(1'b1, 3'b011, 6'd5, 1'b1, 1'b0, 6'd3, 3'd0, 1'b0, 1'b0, "brel_wrap");
      step(1'b1, 3'b011, 6'd20, 1'b0, 1'b0, 6'd4, 3'd0, 1'b0, 1'b0, "brel_not_taken");
      step(1'b1, 3'b110, 6'd20, 1'b1, 1'b0, 6'd5, 3'd0, 1'b0, 1'b0, "reserved110");
      step(1'b1, 3'b111, 6'd20, 1'b1, 1'b0, 6'd6, 3'd0, 1'b0, 1'b0, "reserved111");

      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3'b001, 6'd50, 1'b0, 1'b0, 6'd6, 3'd0, 1'b0, 1'b0, "stall_hold");
      end
      step(1'b1, 3'b001, 6'd50, 1'b0, 1'b0, 6'd50, 3'd0, 1'b0, 1'b0, "stall_release");

      step(1'b1, 3'b001, 6'd5, 1'b0, 1'b0, 6'd5, 3'd0, 1'b0, 1'b0, "jump5");
`ifdef PROGRAM_SEQUENCER_STACK_EN
      step(1'b1, 3'b100, 6'd20, 1'b0, 1'b0, 6'd20, 3'd1, 1'b0, 1'b0, "call20");
      step(1'b1, 3'b100, 6'd30, 1'b0, 1'b0, 6'd30, 3'd2, 1'b0, 1'b0, "call30");
      step(1'b1, 3'b101, 6'd0, 1'b0, 1'b0, 6'd21, 3'd1, 1'b0, 1'b0, "ret_inner");
      step(1'b1, 3'b101, 6'd0, 1'b0, 1'b0, 6'd6, 3'd0, 1'b0, 1'b0, "ret_outer");

      step(1'b1, 3'b001, 6'd10, 1'b0, 1'b0, 6'd10, 3'd0, 1'b0, 1'b0, "jump10b");
      step(1'b1, 3'b100, 6'd20, 1'b0, 1'b0, 6'd20, 3'd1, 1'b0, 1'b0, "fill1");
      step(1'b1, 3'b100, 6'd30, 1'b0, 1'b0, 6'd30, 3'd2, 1'b0, 1'b0, "fill2");
      step(1'b1, 3'b100, 6'd40, 1'b0, 1'b0, 6'd40, 3'd3, 1'b0, 1'b0, "fill3");
      step(1'b1, 3'b100, 6'd50, 1'b0, 1'b0, 6'd50, 3'd4, 1'b0, 1'b0, "fill4");
      step(1'b1, 3'b100, 6'd60, 1'b0, 1'b0, 6'd60, 3'd4, 1'b1, 1'b0, "overflow");
      step(1'b0, 3'b101, 6'd0, 1'b0, 1'b0, 6'd60, 3'd4, 1'b1, 1'b0, "stall_ret");
      step(1'b1, 3'b101, 6'd0, 1'b0, 1'b0, 6'd41, 3'd3, 1'b1, 1'b0, "drain1");
      step(1'b1, 3'b101, 6'd0, 1'b0, 1'b0, 6'd31, 3'd2, 1'b1, 1'b0, "drain2");
      step(1'b1, 3'b101, 6'd0, 1'b0, 1'b0, 6'd21, 3'd1, 1'b1, 1'b0, "drain3");
      step(1'b1, 3'b101, 6'd0, 1'b0, 1'b0, 6'd11, 3'd0, 1'b1, 1'b0, "drain4");
      step(1'b1, 3'b101, 6'd0, 1'b0, 1'b0, 6'd12, 3'd0, 1'b1, 1'b1, "underflow");
      step(1'b0, 3'b000, 6'd0, 1'b0, 1'b1, 6'd12, 3'd0, 1'b0, 1'b0, "clr_err_stalled");

      step(1'b1, 3'b001, 6'd63, 1'b0, 1'b0, 6'd63, 3'd0, 1'b0, 1'b0, "jump63");
      step(1'b1, 3'b100, 6'd7, 1'b0, 1'b0, 6'd7, 3'd1, 1'b0, 1'b0, "call_at_top");
      step(1'b1, 3'b101, 6'd0, 1'b0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, "ret_wrapped");
      step(1'b1, 3'b101, 6'd0, 1'b0, 1'b1, 6'd1, 3'd0, 1'b0, 1'b1, "set_beats_clr");
      step(1'b1, 3'b000, 6'd0, 1'b0, 1'b1, 6'd2, 3'd0, 1'b0, 1'b0, "clr_unf");
`else
      step(1'b1, 3'b100, 6'd20, 1'b0, 1'b0, 6'd20, 3'd0, 1'b0, 1'b0, "call_as_jump");
      step(1'b1, 3'b101, 6'd0, 1'b0, 1'b0, 6'd21, 3'd0, 1'b0, 1'b0, "ret_as_next");
      step(1'b1, 3'b101, 6'd0, 1'b0, 1'b1, 6'd22, 3'd0, 1'b0, 1'b0, "ret_no_unf");
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 3'b100, 6'(10 + i), 1'b0, 1'b0, 6'(10 + i), 3'd0, 1'b0, 1'b0, "call_no_ovf");
      end
`endif

      total++;
      assert (exp_q.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard_leftover: got %0d pending, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
